// File: rtl/counter_phase_pkg.sv
`default_nettype none
// ==== counter_phase_pkg : shared FSM states, phase codes and duration lookup ====
// ==== Rev 1.0 ===================================================================
package counter_phase_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2
    } state_t;

    localparam logic [1:0] PH_NSG = 2'd0;
    localparam logic [1:0] PH_NSY = 2'd1;
    localparam logic [1:0] PH_EWG = 2'd2;
    localparam logic [1:0] PH_EWY = 2'd3;

    // Durations arrive packed as {EWY, EWG, NSY, NSG}; the counter needs T-1 because
    // Q=0 is itself the last counted cycle of a phase.
    function automatic logic [3:0] dur(input logic [1:0] ph, input logic [15:0] tvec);
        logic [3:0] t;
        case (ph)
            PH_NSG:  t = tvec[3:0];
            PH_NSY:  t = tvec[7:4];
            PH_EWG:  t = tvec[11:8];
            default: t = tvec[15:12];
        endcase
        return t - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lamp_decode.sv
`default_nettype none
// ==== lamp_decode : phase + busy -> {NS_R,NS_Y,NS_G,EW_R,EW_Y,EW_G} =============
// ==== Rev 1.0 ===================================================================
module lamp_decode
    import counter_phase_pkg::*;
(
    input  logic [1:0] i_phase,
    input  logic       i_busy,
    output logic [5:0] o_lamps
);

    always_comb begin
        o_lamps = 6'b100_100;
        if (i_busy) begin
            case (i_phase)
                PH_NSG:  o_lamps = 6'b001_100;
                PH_NSY:  o_lamps = 6'b010_100;
                PH_EWG:  o_lamps = 6'b100_001;
                default: o_lamps = 6'b100_010;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_phase_ctrl.sv
`default_nettype none
// ==== counter_phase_ctrl : 4-phase traffic-light sequencer for a 4-bit down counter
// ==== Rev 1.0 ===================================================================
module counter_phase_ctrl
    import counter_phase_pkg::*;
#(
    parameter int T_NSG = 9,
    parameter int T_NSY = 3,
    parameter int T_EWG = 9,
    parameter int T_EWY = 3
) (
    input  logic       CP,
    input  logic       CLR,
    input  logic       EN,
    input  logic       HOLD,
    input  logic       QD,
    input  logic       QC,
    input  logic       QB,
    input  logic       QA,
    output logic       M,
    output logic       LD,
    output logic       D,
    output logic       C,
    output logic       B,
    output logic       A,
    output logic       NS_R,
    output logic       NS_Y,
    output logic       NS_G,
    output logic       EW_R,
    output logic       EW_Y,
    output logic       EW_G,
    output logic [1:0] PHASE,
    output logic       BUSY
);

    if (T_NSG < 1 || T_NSG > 15 || T_NSY < 1 || T_NSY > 15 ||
        T_EWG < 1 || T_EWG > 15 || T_EWY < 1 || T_EWY > 15) begin : g_bad_dur
        $error("counter_phase_ctrl: every phase duration must lie in 1..15");
    end

    localparam logic [15:0] C_TVEC = {4'(T_EWY), 4'(T_EWG), 4'(T_NSY), 4'(T_NSG)};

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_phase;
    logic [1:0] w_phase_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic [5:0] r_lamps;
    logic [5:0] w_lamps_nxt;
    logic [3:0] w_q;
    logic       w_ld;
    logic [3:0] w_dcba;

    assign w_q = {QD, QC, QB, QA};

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        if (!EN) begin
            w_state_nxt = IDLE;
            w_phase_nxt = PH_NSG;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = LOAD;
                    w_phase_nxt = PH_NSG;
                end
                LOAD:    w_state_nxt = COUNT;
                COUNT: begin
                    // HOLD outranks expiry: a frozen timer at zero must not advance
                    if (!HOLD && w_q == 4'd0) begin
                        w_state_nxt = LOAD;
                        w_phase_nxt = r_phase + 2'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_busy_nxt = (w_state_nxt != IDLE);

    lamp_decode u_lamp_decode (
        .i_phase (w_phase_nxt),
        .i_busy  (w_busy_nxt),
        .o_lamps (w_lamps_nxt)
    );

    always_ff @(posedge CP or negedge CLR) begin
        if (!CLR) begin
            r_state <= IDLE;
            r_phase <= PH_NSG;
            r_busy  <= 1'b0;
            r_lamps <= 6'b100_100;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_busy  <= w_busy_nxt;
            r_lamps <= w_lamps_nxt;
        end
    end

    // Counter load path: phase duration in LOAD, self-reload of Q while held
    always_comb begin
        w_ld   = 1'b1;
        w_dcba = 4'd0;
        case (r_state)
            LOAD: begin
                w_ld   = 1'b0;
                w_dcba = dur(r_phase, C_TVEC);
            end
            COUNT: begin
                if (HOLD) begin
                    w_ld   = 1'b0;
                    w_dcba = w_q;
                end
            end
            default: ;
        endcase
    end

    assign M            = 1'b0;
    assign LD           = w_ld;
    assign {D, C, B, A} = w_dcba;
    assign PHASE        = r_phase;
    assign BUSY         = r_busy;
    assign {NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G} = r_lamps;

endmodule
`default_nettype wire

// File: tb/tb_counter_phase_ctrl.sv
`default_nettype none
// ==== tb_counter_phase_ctrl : controller + behavioural up/down counter, vector table
// ==== Rev 1.0 ===================================================================
module tb_counter_phase_ctrl;

    // expected/actual pack: {BUSY, PHASE[1:0], LD, DCBA[3:0], Q[3:0], lamps[5:0], M}
    typedef struct {
        logic        en;
        logic        hold;
        logic        q_chk;
        logic [18:0] exp;
    } vec_t;

    localparam logic [18:0] MASK_ALL = 19'h7FFFF;
    localparam logic [18:0] MASK_NOQ = 19'h7F87F;
    localparam logic [5:0]  REDS     = 6'b100_100;

    logic CP = 1'b0;
    logic CLR = 1'b1;
    logic EN = 1'b0, HOLD = 1'b0, EN1 = 1'b0, HOLD1 = 1'b0;

    logic QD, QC, QB, QA, M, LD, D, C, B, A, NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, BUSY;
    logic [1:0] PHASE;
    logic QD1, QC1, QB1, QA1, M1, LD1, D1, C1, B1, A1, NS_R1, NS_Y1, NS_G1, EW_R1, EW_Y1, EW_G1, BUSY1;
    logic [1:0] PHASE1;

    logic [3:0] r_cnt  = 4'd0;
    logic [3:0] r_cnt1 = 4'd0;

    int checks = 0;
    int errors = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #10 CP = ~CP;

    counter_phase_ctrl dut (
        .CP(CP), .CLR(CLR), .EN(EN), .HOLD(HOLD),
        .QD(QD), .QC(QC), .QB(QB), .QA(QA),
        .M(M), .LD(LD), .D(D), .C(C), .B(B), .A(A),
        .NS_R(NS_R), .NS_Y(NS_Y), .NS_G(NS_G), .EW_R(EW_R), .EW_Y(EW_Y), .EW_G(EW_G),
        .PHASE(PHASE), .BUSY(BUSY)
    );

    counter_phase_ctrl #(.T_NSY(1)) dut_nsy1 (
        .CP(CP), .CLR(CLR), .EN(EN1), .HOLD(HOLD1),
        .QD(QD1), .QC(QC1), .QB(QB1), .QA(QA1),
        .M(M1), .LD(LD1), .D(D1), .C(C1), .B(B1), .A(A1),
        .NS_R(NS_R1), .NS_Y(NS_Y1), .NS_G(NS_G1), .EW_R(EW_R1), .EW_Y(EW_Y1), .EW_G(EW_G1),
        .PHASE(PHASE1), .BUSY(BUSY1)
    );

    // The lab's loadable up/down counter: LD low loads, else M selects direction.
    always @(posedge CP) begin
        if (!LD)      r_cnt <= {D, C, B, A};
        else if (!M)  r_cnt <= r_cnt - 4'd1;
        else          r_cnt <= r_cnt + 4'd1;
        if (!LD1)     r_cnt1 <= {D1, C1, B1, A1};
        else if (!M1) r_cnt1 <= r_cnt1 - 4'd1;
        else          r_cnt1 <= r_cnt1 + 4'd1;
    end
    assign {QD, QC, QB, QA}     = r_cnt;
    assign {QD1, QC1, QB1, QA1} = r_cnt1;

    function automatic logic [5:0] lamps_of(input logic [1:0] ph);
        case (ph)
            2'd0:    return 6'b001_100;
            2'd1:    return 6'b010_100;
            2'd2:    return 6'b100_001;
            default: return 6'b100_010;
        endcase
    endfunction

    function automatic logic [18:0] pk(input logic busy, input logic [1:0] ph, input logic ld,
                                       input logic [3:0] dcba, input logic [3:0] q,
                                       input logic [5:0] lmp);
        return {busy, ph, ld, dcba, q, lmp, 1'b0};
    endfunction

    function automatic logic [18:0] act_main();
        return {BUSY, PHASE, LD, D, C, B, A, QD, QC, QB, QA,
                NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, M};
    endfunction

    function automatic logic [18:0] act_nsy1();
        return {BUSY1, PHASE1, LD1, D1, C1, B1, A1, QD1, QC1, QB1, QA1,
                NS_R1, NS_Y1, NS_G1, EW_R1, EW_Y1, EW_G1, M1};
    endfunction

    task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp,
                       input logic [18:0] mask);
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s got %05h want %05h (busy,ph,ld,dcba,q,lamps,m)",
                     nm, act & mask, exp & mask);
        end
    endtask

    task automatic add_row(input logic en, input logic hold, input logic busy,
                           input logic [1:0] ph, input logic ld, input logic [3:0] dcba,
                           input logic [3:0] q, input logic qchk, input logic [5:0] lmp);
        vec_t v;
        v.en = en; v.hold = hold; v.q_chk = qchk;
        v.exp = pk(busy, ph, ld, dcba, q, lmp);
        tbl.push_back(v);
    endtask

    task automatic add_idle(input int n, input logic en);
        for (int i = 0; i < n; i++) add_row(en, 1'b0, 1'b0, 2'd0, 1'b1, 4'd0, 4'd0, 1'b0, REDS);
    endtask

    // One phase: a LOAD cycle, then T counting cycles Q=T-1..0. Optional HOLD of hn
    // cycles when Q==hq, optional EN drop in the cycle Q==stop_q.
    task automatic add_phase(input logic [1:0] ph, input int t, input int hq, input int hn,
                             input int stop_q);
        add_row(1'b1, 1'b0, 1'b1, ph, 1'b0, 4'(t - 1), 4'd0, 1'b0, lamps_of(ph));
        for (int q = t - 1; q >= 0; q--) begin
            if (q == hq)
                for (int k = 0; k < hn; k++)
                    add_row(1'b1, 1'b1, 1'b1, ph, 1'b0, 4'(q), 4'(q), 1'b1, lamps_of(ph));
            if (q == stop_q) begin
                add_row(1'b0, 1'b0, 1'b1, ph, 1'b1, 4'd0, 4'(q), 1'b1, lamps_of(ph));
                return;
            end
            add_row(1'b1, 1'b0, 1'b1, ph, 1'b1, 4'd0, 4'(q), 1'b1, lamps_of(ph));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   found;

        // Table: idle, NSG stretched by HOLD at Q=5, full round, NSG held at Q=0,
        // full round, partial round with EN drop mid-EWG, restart at NSG.
        add_idle(10, 1'b0);
        add_idle(1, 1'b1);
        add_phase(2'd0, 9, 5, 5, -1);
        add_phase(2'd1, 3, -1, 0, -1);
        add_phase(2'd2, 9, -1, 0, -1);
        add_phase(2'd3, 3, -1, 0, -1);
        add_phase(2'd0, 9, 0, 3, -1);
        add_phase(2'd1, 3, -1, 0, -1);
        add_phase(2'd2, 9, -1, 0, -1);
        add_phase(2'd3, 3, -1, 0, -1);
        add_phase(2'd0, 9, -1, 0, -1);
        add_phase(2'd1, 3, -1, 0, -1);
        add_phase(2'd2, 9, -1, 0, 4);
        add_idle(2, 1'b0);
        add_idle(1, 1'b1);
        add_phase(2'd0, 9, -1, 0, -1);

        // Asynchronous reset takes effect before any clock edge
        #2 CLR = 1'b0;
        #3 chk("reset_async", act_main(), pk(1'b0, 2'd0, 1'b1, 4'd0, 4'd0, REDS), MASK_NOQ);
        @(negedge CP);
        @(negedge CP);
        CLR = 1'b1;

        foreach (tbl[i]) begin
            @(negedge CP);
            EN   = tbl[i].en;
            HOLD = tbl[i].hold;
            sb.push_back(tbl[i]);
            #1;
            v = sb.pop_front();
            chk($sformatf("row%0d", i), act_main(), v.exp, v.q_chk ? MASK_ALL : MASK_NOQ);
        end

        // CLR pulsed between edges while counting
        @(negedge CP);
        #1 chk("busy_before_clr", {18'd0, BUSY}, 19'd1, MASK_ALL);
        #2 CLR = 1'b0;
        #2 chk("clr_midcount", act_main(), pk(1'b0, 2'd0, 1'b1, 4'd0, 4'd0, REDS), MASK_NOQ);
        EN = 1'b0;
        @(negedge CP);
        CLR = 1'b1;

        // T_NSY=1: NSY is LOAD(DCBA=0) plus a single COUNT cycle at Q=0
        EN1 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge CP);
            #1;
            if (BUSY1 && PHASE1 == 2'd1 && !LD1) found = 1'b1;
        end
        chk("nsy1_reached", {18'd0, found}, 19'd1, MASK_ALL);
        if (found) begin
            chk("nsy1_load", act_nsy1(), pk(1'b1, 2'd1, 1'b0, 4'd0, 4'd0, 6'b010_100), MASK_NOQ);
            @(negedge CP);
            #1 chk("nsy1_count", act_nsy1(), pk(1'b1, 2'd1, 1'b1, 4'd0, 4'd0, 6'b010_100), MASK_ALL);
            @(negedge CP);
            #1 chk("nsy1_next_ewg", act_nsy1(), pk(1'b1, 2'd2, 1'b0, 4'd8, 4'd0, 6'b100_001), MASK_NOQ);
        end
        EN1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
